// File: rtl/seq_player_pkg.sv
// Shared definitions for the sequence player and the upcoming input-compare stage:
// state encoding, default dwell constants and a small sizing helper.
package playseq_pkg;

  localparam int unsigned DEF_ON_CYCLES  = 1000;
  localparam int unsigned DEF_OFF_CYCLES = 500;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_SHOW = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_LOAD = ST_LOAD,
    S_SHOW = ST_SHOW,
    S_GAP  = ST_GAP,
    S_DONE = ST_DONE
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_player_if.sv
// Control, display and RAM-read signals of the sequence player.
// master = the player itself; slave = its environment (controller, RAM, LEDs).
interface seq_player_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] limit;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] leds;
  logic [ADDR_W-1:0] step;
  logic              busy;
  logic              done;

  modport master (
    input  start, stop, limit, ram_q,
    output ram_addr, leds, step, busy, done
  );

  modport slave (
    output start, stop, limit, ram_q,
    input  ram_addr, leds, step, busy, done
  );
endinterface

// File: rtl/seq_player_dwell_timer.sv
// Dwell counter for the SHOW/GAP phases; tc flags the cycle the count reaches term
// while enabled, and the owner clears it on that same cycle to restart from zero.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == term);

endmodule

// File: rtl/seq_player.sv
// Plays RAM words 0..limit onto the LEDs: ON_CYCLES shown, OFF_CYCLES blank per word,
// then a one-cycle done pulse. Read-only master of the synchronous RAM port.
module seq_player
  import playseq_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = int'(DEF_ON_CYCLES),
  parameter int OFF_CYCLES = int'(DEF_OFF_CYCLES)
) (
  input logic              clk,
  input logic              reset,
  seq_player_if.master     bus
);

  localparam int TW = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmr_clear, tmr_en, tmr_tc;
  logic [TW-1:0]     tmr_term;

  // Timer runs only in SHOW/GAP and restarts from zero on every terminal count.
  always_comb begin
    tmr_en    = (state_q == S_SHOW) || (state_q == S_GAP);
    tmr_clear = !tmr_en || tmr_tc || bus.stop;
    tmr_term  = (state_q == S_SHOW) ? TW'(ON_CYCLES - 1) : TW'(OFF_CYCLES - 1);
  end

  dwell_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .en    (tmr_en),
    .term  (tmr_term),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    limit_d    = limit_q;
    leds_d     = leds_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE && bus.stop) begin
      state_d    = S_IDLE;
      leds_d     = '0;
      busy_d     = 1'b0;
      ram_addr_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            limit_d    = bus.limit;
            ram_addr_d = '0;
            busy_d     = 1'b1;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: state_d = S_LOAD;
        S_LOAD: begin
          leds_d  = bus.ram_q;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (tmr_tc) begin
            leds_d  = '0;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (tmr_tc) begin
            if (ram_addr_q == limit_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              ram_addr_d = ram_addr_q + ADDR_W'(1);
              state_d    = S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ram_addr_q <= '0;
      limit_q    <= '0;
      leds_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      limit_q    <= limit_d;
      leds_q     <= leds_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.step     = ram_addr_q;
  assign bus.leds     = leds_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with ON=3, OFF=2 (7 cycles per word) and a RAM
// holding 1,2,4,8 repeating; outputs are sampled on the falling edge every cycle.
module tb_seq_player;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [3:0] mem [16];

  seq_player_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  seq_player #(
    .ADDR_W(4), .DATA_W(4), .ON_CYCLES(3), .OFF_CYCLES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
  end

  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  // Expected LEDs k cycles after the start edge: word w lit at offsets 2..4 of its 7-cycle slot.
  function automatic logic [3:0] exp_leds(input int k, input int lim);
    int w = k / 7;
    int o = k % 7;
    if (w <= lim && o >= 2 && o <= 4) return 4'(1 << (w % 4));
    return 4'd0;
  endfunction

  function automatic logic [3:0] exp_step(input int k, input int lim);
    return (k / 7 < lim) ? 4'(k / 7) : 4'(lim);
  endfunction

  task automatic begin_play(input logic [3:0] lim);
    @(negedge clk);
    bus.start = 1'b1;
    bus.limit = lim;
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.limit = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.leds, bus.ram_addr, bus.busy, bus.done} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: leds=%b addr=%0d busy=%b done=%b, want all zero",
               bus.leds, bus.ram_addr, bus.busy, bus.done);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  // Full playback with per-cycle checks; dk is the hand-computed done cycle.
  task automatic test_play(input string name, input int lim, input int dk);
    begin_play(4'(lim));
    for (int k = 0; k <= dk + 1; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      n_checks += 4;
      if (bus.leds !== exp_leds(k, lim)) begin
        n_fail++;
        $display("FAIL %s_leds k=%0d: got %b want %b", name, k, bus.leds, exp_leds(k, lim));
      end
      if (bus.step !== exp_step(k, lim)) begin
        n_fail++;
        $display("FAIL %s_step k=%0d: got %0d want %0d", name, k, bus.step, exp_step(k, lim));
      end
      if (bus.busy !== (k <= dk)) begin
        n_fail++;
        $display("FAIL %s_busy k=%0d: got %b want %b", name, k, bus.busy, k <= dk);
      end
      if (bus.done !== (k == dk)) begin
        n_fail++;
        $display("FAIL %s_done k=%0d: got %b want %b", name, k, bus.done, k == dk);
      end
    end
  endtask

  // limit=3 with a start(limit=1) pulse mid-play; limit_reg must stay 3, done at 28.
  task automatic test_start_while_busy;
    begin_play(4'd3);
    for (int k = 0; k <= 29; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (k == 10) begin bus.start = 1'b1; bus.limit = 4'd1; end
      if (k == 11) bus.start = 1'b0;
      n_checks += 4;
      if (bus.leds !== exp_leds(k, 3)) begin
        n_fail++;
        $display("FAIL busy_start_leds k=%0d: got %b want %b", k, bus.leds, exp_leds(k, 3));
      end
      if (bus.step !== exp_step(k, 3)) begin
        n_fail++;
        $display("FAIL busy_start_step k=%0d: got %0d want %0d", k, bus.step, exp_step(k, 3));
      end
      if (bus.busy !== (k <= 28)) begin
        n_fail++;
        $display("FAIL busy_start_busy k=%0d: got %b want %b", k, bus.busy, k <= 28);
      end
      if (bus.done !== (k == 28)) begin
        n_fail++;
        $display("FAIL busy_start_done k=%0d: got %b want %b", k, bus.done, k == 28);
      end
    end
  endtask

  // Stop sampled at k=10 (second word's SHOW): everything zero from then on, no done.
  task automatic test_stop;
    logic [3:0] wl, ws;
    logic       wb;
    begin_play(4'd3);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (k == 9) bus.stop = 1'b1;
      if (k == 10) bus.stop = 1'b0;
      wl = (k >= 10) ? 4'd0 : exp_leds(k, 3);
      ws = (k >= 10) ? 4'd0 : exp_step(k, 3);
      wb = (k < 10);
      n_checks += 4;
      if (bus.leds !== wl) begin
        n_fail++;
        $display("FAIL stop_leds k=%0d: got %b want %b", k, bus.leds, wl);
      end
      if (bus.step !== ws) begin
        n_fail++;
        $display("FAIL stop_step k=%0d: got %0d want %0d", k, bus.step, ws);
      end
      if (bus.busy !== wb) begin
        n_fail++;
        $display("FAIL stop_busy k=%0d: got %b want %b", k, bus.busy, wb);
      end
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_done k=%0d: got %b want 0", k, bus.done);
      end
    end
  endtask

  task automatic test_start_stop_idle;
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.limit = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.busy !== 1'b0 || bus.leds !== 4'd0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL start_stop_idle k=%0d: busy=%b leds=%b done=%b, want 0 0000 0",
                 k, bus.busy, bus.leds, bus.done);
      end
      @(negedge clk);
    end
  endtask

  // Reset lands in the second word's GAP (k=12, step=1) and must clear outputs at once.
  task automatic test_reset_mid_gap;
    begin_play(4'd3);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
    end
    n_checks++;
    if (bus.step !== 4'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_gap: step=%0d busy=%b, want 1 1", bus.step, bus.busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.leds, bus.ram_addr, bus.busy, bus.done} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_gap: leds=%b addr=%0d busy=%b done=%b, want all zero",
               bus.leds, bus.ram_addr, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.leds !== 4'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle k=%0d: busy=%b done=%b leds=%b, want 0 0 0000",
                 k, bus.busy, bus.done, bus.leds);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_play("lim0", 0, 7);
    test_play("lim3", 3, 28);
    test_play("lim15", 15, 112);
    test_start_while_busy();
    test_stop();
    test_play("replay", 3, 28);
    test_start_stop_idle();
    test_reset_mid_gap();
    test_play("after_reset", 0, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
